fdiv_issue: RTL and testbench

- Issue/retire controller directly upstream and downstream of the pipelined `fdiv` datapath.
- Accepts divide requests on a valid/ready interface and drives the registered operands into `fdiv`.
- Tracks in-flight ops with a LAT-deep valid/tag shift register and captures `fdiv.y` into a result FIFO.
- Returns results in order on a valid/ready response interface; `fdiv` has no enable, so credit-based issue guarantees no result is ever dropped.

---
 rtl/fdiv_issue.sv | 123 ++++++++++++
 tb/tb_fdiv_issue.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_issue.sv
// Issue/retire controller around the fixed-latency, enable-less fdiv pipeline.
// Credit-based issue reserves a result FIFO slot per in-flight op so nothing leaving fdiv is lost.
module fdiv_issue #(
  parameter int LAT   = 12,
  parameter int DEPTH = 16,
  parameter int TAGW  = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_x1,
  input  logic [31:0]     req_x2,
  input  logic [TAGW-1:0] req_tag,
  output logic [31:0]     div_x1,
  output logic [31:0]     div_x2,
  input  logic [31:0]     div_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_y,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_dz,
  output logic            busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic            dz;
    logic            sgn;
  } meta_t;

  typedef struct packed {
    logic [31:0]     y;
    logic [TAGW-1:0] tag;
    logic            dz;
  } ent_t;

  logic [LAT:0]  vld_pipe;
  meta_t         meta_pipe [LAT+1];
  ent_t          mem [DEPTH];
  ent_t          wr_ent;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] inflight, fifo_cnt;
  logic          acc, wr, pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Ready looks only at registered counters so it never combinationally depends on rsp_ready.
  assign req_ready = (SW'(inflight) + SW'(fifo_cnt)) < SW'(DEPTH);
  assign acc       = req_valid & req_ready;
  assign wr        = vld_pipe[LAT];
  assign rsp_valid = (fifo_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign busy      = (inflight != '0) | rsp_valid;

  always_comb begin
    wr_ent     = '0;
    wr_ent.tag = meta_pipe[LAT].tag;
    wr_ent.dz  = meta_pipe[LAT].dz;
    wr_ent.y   = meta_pipe[LAT].dz ? {meta_pipe[LAT].sgn, 8'hFF, 23'h0} : div_y;
  end

  // Operands and metadata only load on accept; idle cycles leave fdiv inputs quiet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_x1   <= '0;
      div_x2   <= '0;
      vld_pipe <= '0;
      for (int i = 0; i <= LAT; i++) meta_pipe[i] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LAT-1:0], acc};
      if (acc) begin
        div_x1       <= req_x1;
        div_x2       <= req_x2;
        meta_pipe[0] <= '{tag: req_tag, dz: (req_x2[30:23] == 8'd0), sgn: req_x1[31] ^ req_x2[31]};
      end
      for (int i = 1; i <= LAT; i++) meta_pipe[i] <= meta_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= '0;
    end else begin
      case ({acc, wr})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // A retiring op already holds a credit, so the FIFO cannot be full when wr is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= wr_ent;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign rsp_y   = mem[rd_ptr].y;
  assign rsp_tag = mem[rd_ptr].tag;
  assign rsp_dz  = mem[rd_ptr].dz;

endmodule

// File: tb/tb_fdiv_issue.sv
// Bench for fdiv_issue: a behavioural fdiv stand-in feeds div_y, and a queue-based
// reference model predicts handshakes, response timing and the returned values.
module tb_fdiv_issue;
  localparam int LAT   = 12;
  localparam int DEPTH = 16;
  localparam int TAGW  = 6;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic            req_valid = 1'b0, req_ready;
  logic [31:0]     req_x1 = '0, req_x2 = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic [31:0]     div_x1, div_x2, div_y;
  logic            rsp_valid, rsp_ready = 1'b0;
  logic [31:0]     rsp_y;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_dz, busy;

  always #5 clk = ~clk;

  fdiv_issue #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .div_x1(div_x1), .div_x2(div_x2), .div_y(div_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_tag(rsp_tag), .rsp_dz(rsp_dz), .busy(busy)
  );

  // Quotient via double-precision real arithmetic, truncated back to single; normals only.
  function automatic logic [31:0] fdiv_ref(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] da, db, dq;
    logic [10:0] e;
    real         q;
    if (a[30:23] == 8'd0 || a[30:23] == 8'hFF || b[30:23] == 8'd0 || b[30:23] == 8'hFF)
      return 32'hDEADBEEF;
    da = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
    db = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    q  = $bitstoreal(da) / $bitstoreal(db);
    dq = $realtobits(q);
    e  = dq[62:52];
    if (e < 11'd897 || e > 11'd1150) return 32'h0;
    return {dq[63], 8'(e - 11'd896), dq[51:29]};
  endfunction

  // fdiv stand-in: samples operands each edge, result valid LAT edges later; never reset.
  logic [31:0] fpipe [LAT];
  always @(posedge clk) begin
    fpipe[0] <= fdiv_ref(div_x1, div_x2);
    for (int i = 1; i < LAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign div_y = fpipe[LAT-1];

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0]     y;
    logic [TAGW-1:0] tag;
    logic            dz;
    int              e;
  } exp_t;
  exp_t q[$];
  int   cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: every accepted op is owed one in-order response, visible LAT+1 edges after accept.
  initial forever begin
    exp_t ent;
    logic ev;
    @(negedge clk);
    if (!rstn) begin
      q.delete();
    end else begin
      chk("req_ready", 32'(req_ready), 32'(q.size() < DEPTH));
      chk("busy", 32'(busy), 32'(q.size() != 0));
      ev = 1'b0;
      if (q.size() > 0) ev = (cyc >= q[0].e + LAT + 1);
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (rsp_valid && q.size() > 0) begin
        chk("rsp_y", rsp_y, q[0].y);
        chk("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
        chk("rsp_dz", 32'(rsp_dz), 32'(q[0].dz));
        if (rsp_ready) void'(q.pop_front());
      end
      if (req_valid && req_ready) begin
        ent.dz  = (req_x2[30:23] == 8'd0);
        ent.y   = ent.dz ? {req_x1[31] ^ req_x2[31], 8'hFF, 23'h0} : fdiv_ref(req_x1, req_x2);
        ent.tag = req_tag;
        ent.e   = cyc + 1;
        q.push_back(ent);
      end
    end
  end

  task automatic rnd_op();
    logic [7:0] ex;
    ex      = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(100, 154));
    req_x1  = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    req_x2  = {1'($urandom), ex, 23'($urandom)};
    req_tag = TAGW'($urandom);
  endtask

  // One cycle starting and ending at posedge+1; new operands follow each accept.
  task automatic step(output bit a, output bit rv);
    @(negedge clk);
    a  = req_valid && req_ready;
    rv = rsp_valid;
    @(posedge clk); #1;
    if (a) rnd_op();
  endtask

  task automatic issue(input logic [31:0] x1, input logic [31:0] x2, input logic [TAGW-1:0] t);
    int n = 0;
    req_valid = 1'b1; req_x1 = x1; req_x2 = x2; req_tag = t;
    do begin @(negedge clk); n++; end while (!req_ready && n < 200);
    chk("issue_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, input logic [31:0] y, input logic [TAGW-1:0] t,
                          input logic dz, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 200);
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_y"}, rsp_y, y);
    chk({nm, "_tag"}, 32'(rsp_tag), 32'(t));
    chk({nm, "_dz"}, 32'(rsp_dz), 32'(dz));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while (busy && n < 500) begin @(posedge clk); #1; n++; end
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, tg, first_nr, nacc, nv, bad_occ, guard, nb;
    bit  a, rv;

    // Reset values
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_div_x1", div_x1, 32'd0);
    chk("rst_div_x2", div_x2, 32'd0);
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rsp_dz", 32'(rsp_dz), 32'd0);
    @(posedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1;

    // Single op latency and value
    rsp_ready = 1'b1;
    issue(32'h40C00000, 32'h40000000, 6'd5);
    wait_rsp("t1", 32'h40400000, 6'd5, 1'b0, n);
    chk("t1_latency", 32'(n), 32'(LAT + 2));
    @(negedge clk);
    chk("t1_busy_low", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Divide by signed zero
    issue(32'h3F800000, 32'h80000000, 6'd1);
    wait_rsp("dz_neg", 32'hFF800000, 6'd1, 1'b1, n);
    issue(32'h3F800000, 32'h00000000, 6'd2);
    wait_rsp("dz_pos", 32'h7F800000, 6'd2, 1'b1, n);

    // Backpressure: exactly DEPTH credits, then in-order drain
    rsp_ready = 1'b0;
    tg = 0; nacc = 0; first_nr = 0;
    rnd_op(); req_tag = TAGW'(tg); req_valid = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step(a, rv);
      if (a) begin nacc++; tg++; req_tag = TAGW'(tg); end
      else if (first_nr == 0) first_nr = c;
    end
    chk("bp_accepts", 32'(nacc), 32'(DEPTH));
    chk("bp_first_stall", 32'(first_nr), 32'(DEPTH + 1));
    rsp_ready = 1'b1;
    step(a, rv);
    chk("bp_hold_until_pop", 32'(a), 32'd0);
    step(a, rv);
    chk("bp_reassert", 32'(a), 32'd1);
    if (a) begin tg++; req_tag = TAGW'(tg); end
    n = 0;
    while (tg < 20 && n < 200) begin
      step(a, rv);
      if (a) begin tg++; req_tag = TAGW'(tg); end
      n++;
    end
    chk("bp_all_accepted", 32'(tg), 32'd20);
    drain();

    // Full FIFO with simultaneous pop and accept every cycle
    rsp_ready = 1'b0;
    rnd_op(); req_valid = 1'b1;
    n = 0;
    do begin step(a, rv); n++; end while (a && n < 40);
    repeat (LAT + 4) step(a, rv);
    chk("full_occ_start", 32'(q.size()), 32'(DEPTH));
    rsp_ready = 1'b1;
    nv = 0; bad_occ = 0;
    for (int c = 0; c < 60; c++) begin
      step(a, rv);
      if (rv) nv++;
      if (q.size() != DEPTH - 1) bad_occ++;
    end
    chk("full_rate", 32'(nv), 32'd60);
    chk("full_occ_const", 32'(bad_occ), 32'd0);
    drain();

    // Random stream
    nacc = 0; guard = 0;
    req_valid = 1'b0;
    while (nacc < 1000 && guard < 20000) begin
      if (!req_valid && $urandom_range(0, 9) < 7) begin req_valid = 1'b1; rnd_op(); end
      rsp_ready = ($urandom_range(0, 9) < 6);
      step(a, rv);
      if (a) begin nacc++; req_valid = 1'b0; end
      guard++;
    end
    chk("rand_count", 32'(nacc), 32'd1000);
    drain();

    // Reset while ops are in flight
    rsp_ready = 1'b1;
    rnd_op(); req_valid = 1'b1;
    nacc = 0; n = 0;
    while (nacc < 5 && n < 50) begin step(a, rv); if (a) nacc++; n++; end
    req_valid = 1'b0;
    chk("rst_mid_accepts", 32'(nacc), 32'd5);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    nb = 0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      if (rsp_valid) nb++;
    end
    chk("rst_quiet", 32'(nb), 32'd0);
    @(posedge clk); #1;
    issue(32'h41200000, 32'h40A00000, 6'd9);
    wait_rsp("post_rst", 32'h40000000, 6'd9, 1'b0, n);
    chk("post_rst_latency", 32'(n), 32'(LAT + 2));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
